// File: rtl/time_seq_pkg.sv
// Shared constants and state encoding for the mm:ss (optionally hh:mm:ss) time sequencer.
// Optional hour support is enabled by defining TIME_SEQ_CTRL_HOUR_EN.
package time_seq_pkg;

  localparam int unsigned DIG_W     = 4;
  localparam int unsigned LO_MAX    = 9;
  localparam int unsigned HI_MAX    = 5;
  localparam int unsigned HR_MAX    = 23;
  localparam int unsigned LO_MOD    = LO_MAX + 1;
  localparam int unsigned HI_MOD    = HI_MAX + 1;
  localparam int unsigned HR_LO_TOP = HR_MAX % 10;
  localparam int unsigned HR_HI_TOP = HR_MAX / 10;
  localparam int unsigned HR_HI_MOD = HR_HI_TOP + 1;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_MIN  = 2'd1,
    ST_SET_SEC  = 2'd2
`ifdef TIME_SEQ_CTRL_HOUR_EN
    ,ST_SET_HOUR = 2'd3
`endif
  } state_t;

endpackage

// File: rtl/time_seq_ctrl_digit_cnt.sv
// Single BCD-style digit counter: modulo MOD, sync clear, increment on enable, carry out.
module digit_cnt
  import time_seq_pkg::*;
#(
  parameter int unsigned MOD = 10
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [DIG_W-1:0] o_q,
  output logic             o_co_c
);

  logic [DIG_W-1:0] r_q;

  // Carry fires on the increment that wraps the digit back to zero.
  assign o_co_c = i_en && (r_q == DIG_W'(MOD - 1));
  assign o_q    = r_q;

  // Digit register: reset/clear win over increment.
  always_ff @(posedge clk) begin
    if (i_rst || i_clr) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= o_co_c ? '0 : r_q + DIG_W'(1);
    end
  end

endmodule

// File: rtl/time_seq_ctrl.sv
// Clock time sequencer: runs on a 1 Hz tick, fields editable in SET states.
// Define TIME_SEQ_CTRL_HOUR_EN to add hour digits and the SET_HOUR state.
module time_seq_ctrl
  import time_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             mode_btn,
  input  logic             inc_btn,
  output logic [DIG_W-1:0] sec_lo,
  output logic [DIG_W-1:0] sec_hi,
  output logic [DIG_W-1:0] min_lo,
  output logic [DIG_W-1:0] min_hi,
  output logic [1:0]       mode,
  output logic             blink,
  output logic             hr_co
`ifdef TIME_SEQ_CTRL_HOUR_EN
  ,output logic [DIG_W-1:0] hr_lo
  ,output logic [DIG_W-1:0] hr_hi
`endif
);

  state_t r_state;
  state_t w_state_nxt;
  logic   r_blink;
  logic   r_hr_co;

  logic w_run_tick, w_min_inc, w_sec_inc;
  logic w_sl_en, w_sh_en, w_ml_en, w_mh_en;
  logic w_sl_co, w_sh_co, w_ml_co, w_mh_co;
  logic w_hr_co_c;

  // Field increment sources are qualified by the state held before any transition.
  assign w_run_tick = (r_state == ST_RUN) && tick;
  assign w_min_inc  = (r_state == ST_SET_MIN) && inc_btn;
  assign w_sec_inc  = (r_state == ST_SET_SEC) && inc_btn;

  // Carries only cross field boundaries while running.
  assign w_sl_en = w_run_tick || w_sec_inc;
  assign w_sh_en = w_sl_co;
  assign w_ml_en = (w_run_tick && w_sh_co) || w_min_inc;
  assign w_mh_en = w_ml_co;

  digit_cnt #(.MOD(LO_MOD)) u_sec_lo (.clk(clk), .i_rst(rst), .i_clr(1'b0), .i_en(w_sl_en), .o_q(sec_lo), .o_co_c(w_sl_co));
  digit_cnt #(.MOD(HI_MOD)) u_sec_hi (.clk(clk), .i_rst(rst), .i_clr(1'b0), .i_en(w_sh_en), .o_q(sec_hi), .o_co_c(w_sh_co));
  digit_cnt #(.MOD(LO_MOD)) u_min_lo (.clk(clk), .i_rst(rst), .i_clr(1'b0), .i_en(w_ml_en), .o_q(min_lo), .o_co_c(w_ml_co));
  digit_cnt #(.MOD(HI_MOD)) u_min_hi (.clk(clk), .i_rst(rst), .i_clr(1'b0), .i_en(w_mh_en), .o_q(min_hi), .o_co_c(w_mh_co));

`ifdef TIME_SEQ_CTRL_HOUR_EN
  logic w_hr_inc, w_hl_en, w_hh_en, w_hl_co, w_hh_co, w_hr_top, w_hr_wrap;

  // Hours wrap 23->00 by clearing both digits instead of counting to 29.
  assign w_hr_inc  = (r_state == ST_SET_HOUR) && inc_btn;
  assign w_hl_en   = (w_run_tick && w_mh_co) || w_hr_inc;
  assign w_hh_en   = w_hl_co;
  assign w_hr_top  = (hr_hi == DIG_W'(HR_HI_TOP)) && (hr_lo == DIG_W'(HR_LO_TOP));
  assign w_hr_wrap = (w_hl_en && w_hr_top) || w_hh_co;

  digit_cnt #(.MOD(LO_MOD))    u_hr_lo (.clk(clk), .i_rst(rst), .i_clr(w_hr_wrap), .i_en(w_hl_en), .o_q(hr_lo), .o_co_c(w_hl_co));
  digit_cnt #(.MOD(HR_HI_MOD)) u_hr_hi (.clk(clk), .i_rst(rst), .i_clr(w_hr_wrap), .i_en(w_hh_en), .o_q(hr_hi), .o_co_c(w_hh_co));

  assign w_hr_co_c = w_run_tick && w_mh_co && w_hr_top;
`else
  assign w_hr_co_c = w_run_tick && w_mh_co;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: one step around the mode ring per mode_btn pulse.
  always_comb begin
    w_state_nxt = r_state;
    if (mode_btn) begin
      case (r_state)
        ST_RUN:      w_state_nxt = ST_SET_MIN;
        ST_SET_MIN:  w_state_nxt = ST_SET_SEC;
`ifdef TIME_SEQ_CTRL_HOUR_EN
        ST_SET_SEC:  w_state_nxt = ST_SET_HOUR;
        ST_SET_HOUR: w_state_nxt = ST_RUN;
`else
        ST_SET_SEC:  w_state_nxt = ST_RUN;
`endif
        default:     w_state_nxt = ST_RUN;
      endcase
    end
  end

  // Registered status outputs, aligned with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blink <= 1'b0;
      r_hr_co <= 1'b0;
    end else begin
      r_blink <= (w_state_nxt != ST_RUN);
      r_hr_co <= w_hr_co_c;
    end
  end

  assign mode  = r_state;
  assign blink = r_blink;
  assign hr_co = r_hr_co;

endmodule

// File: tb/tb_time_seq_ctrl.sv
// Self-checking bench for time_seq_ctrl (default build; hour checks under TIME_SEQ_CTRL_HOUR_EN).
module tb_time_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       mode_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic [3:0] sec_lo, sec_hi, min_lo, min_hi;
  logic [1:0] mode;
  logic       blink, hr_co;
`ifdef TIME_SEQ_CTRL_HOUR_EN
  logic [3:0] hr_lo, hr_hi;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  time_seq_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .sec_lo(sec_lo), .sec_hi(sec_hi), .min_lo(min_lo), .min_hi(min_hi),
    .mode(mode), .blink(blink), .hr_co(hr_co)
`ifdef TIME_SEQ_CTRL_HOUR_EN
    ,.hr_lo(hr_lo), .hr_hi(hr_hi)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r, t, m, i;
    logic [15:0] tm;
    logic [1:0]  md;
    logic        bl;
    logic        co;
  } vec_t;

  vec_t tbl[13];

  function automatic logic [15:0] now_t();
    return {min_hi, min_lo, sec_hi, sec_lo};
  endfunction

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic r, input logic t, input logic m, input logic i);
    rst = r; tick = t; mode_btn = m; inc_btn = i;
    @(posedge clk);
    #1;
    rst = 1'b0; tick = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;
  endtask

  // Load mm:ss through the SET states and return to RUN (hours left at 00).
  task automatic preload(input int mm, input int ss);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < mm; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < ss; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
`ifdef TIME_SEQ_CTRL_HOUR_EN
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
`endif
  endtask

  initial begin
    logic seen_co;

    //          r     t     m     i     mm:ss      mode  blink co
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 2'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 2'd0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0002, 2'd0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0002, 2'd1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0002, 2'd1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0102, 2'd1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0202, 2'd2, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0203, 2'd2, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0203, 2'd2, 1'b1, 1'b0};
`ifdef TIME_SEQ_CTRL_HOUR_EN
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0203, 2'd3, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0203, 2'd0, 1'b0, 1'b0};
`else
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0203, 2'd0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0204, 2'd1, 1'b1, 1'b0};
`endif
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 2'd0, 1'b0, 1'b0};

    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int v = 0; v < 13; v++) begin
      cyc(tbl[v].r, tbl[v].t, tbl[v].m, tbl[v].i);
      chk($sformatf("vec%0d_time", v),  now_t(),     tbl[v].tm);
      chk($sformatf("vec%0d_mode", v),  16'(mode),   16'(tbl[v].md));
      chk($sformatf("vec%0d_blink", v), 16'(blink),  16'(tbl[v].bl));
      chk($sformatf("vec%0d_hr_co", v), 16'(hr_co),  16'(tbl[v].co));
    end

    // 75 ticks from reset -> 01:15, no rollover pulse.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    seen_co = 1'b0;
    for (int k = 0; k < 75; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      if (hr_co) seen_co = 1'b1;
    end
    chk("run75_time", now_t(), 16'h0115);
    chk("run75_no_co", 16'(seen_co), 16'h0);

    // 59:58 + 2 ticks -> 00:00 with a single-cycle hr_co.
    preload(59, 58);
    chk("pre5958_time", now_t(), 16'h5958);
    chk("pre5958_mode", 16'(mode), 16'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t5959_time", now_t(), 16'h5959);
    chk("t5959_co", 16'(hr_co), 16'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("roll_time", now_t(), 16'h0000);
`ifdef TIME_SEQ_CTRL_HOUR_EN
    chk("roll_co", 16'(hr_co), 16'h0);
    chk("roll_hours", 16'({hr_hi, hr_lo}), 16'h0001);
`else
    chk("roll_co", 16'(hr_co), 16'h1);
`endif
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("roll_co_drop", 16'(hr_co), 16'h0);
    chk("roll_time_hold", now_t(), 16'h0000);

    // SET_MIN: 61 increments with interleaved ticks -> 01:00.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 61; k++) cyc(1'b0, (k % 3) == 0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("setmin_time", now_t(), 16'h0100);
    chk("setmin_blink", 16'(blink), 16'h1);
    chk("setmin_mode", 16'(mode), 16'h1);

    // Tick and mode together at 00:09.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("at0009_time", now_t(), 16'h0009);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("tickmode_time", now_t(), 16'h0010);
    chk("tickmode_mode", 16'(mode), 16'h1);

    // Reset mid-SET_SEC edit at 12:34.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 12; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 34; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("setsec_time", now_t(), 16'h1234);
    chk("setsec_mode", 16'(mode), 16'h2);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rstset_time", now_t(), 16'h0000);
    chk("rstset_mode", 16'(mode), 16'h0);
    chk("rstset_blink", 16'(blink), 16'h0);

`ifdef TIME_SEQ_CTRL_HOUR_EN
    // 23:59:59 + tick -> 00:00:00 with hr_co pulse.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 59; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 59; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 23; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("sethr_hours", 16'({hr_hi, hr_lo}), 16'h0023);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("sethr_wrap", 16'({hr_hi, hr_lo}), 16'h0000);
    chk("sethr_min_hold", now_t(), 16'h5959);
    for (int k = 0; k < 23; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("h235959_time", {hr_hi, hr_lo, min_hi, min_lo}, 16'h2359);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("hroll_time", now_t(), 16'h0000);
    chk("hroll_hours", 16'({hr_hi, hr_lo}), 16'h0000);
    chk("hroll_co", 16'(hr_co), 16'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("hroll_co_drop", 16'(hr_co), 16'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/time_seq_ctrl.md
TIME_SEQ_CTRL -- requirements
Module: time_seq_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single system clock, rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port tick, input, 1, one-cycle 1 Hz strobe, synchronous to clk.
REQ-004 SHALL have port mode_btn, input, 1, one-cycle pulse, advances mode.
REQ-005 SHALL have port inc_btn, input, 1, one-cycle pulse, increments selected field.
REQ-006 SHALL have ports sec_lo, sec_hi, min_lo, min_hi, output, 4 each, BCD digits (lo 0-9, hi 0-5).
REQ-007 SHALL have port mode, output, 2, current state encoding (RUN=0, SET_MIN=1, SET_SEC=2, SET_HOUR=3).
REQ-008 SHALL have port blink, output, 1, high while in any SET state.
REQ-009 SHALL have port hr_co, output, 1, one-cycle pulse on 59:59->00:00 rollover.

Function
REQ-010 SHALL implement FSM RUN -> SET_MIN -> SET_SEC -> RUN, advancing one state per mode_btn pulse.
REQ-011 In RUN, each tick SHALL advance the time by one second; digits registered, visible the cycle after tick.
REQ-012 Cascade SHALL be sec_lo mod 10 -> sec_hi mod 6 -> min_lo mod 10 -> min_hi mod 6; a carry enables the next digit in the same cycle.
REQ-013 At 59:59 with tick in RUN, all digits SHALL go to 0 and hr_co SHALL pulse for exactly one cycle.
REQ-014 In SET states, tick SHALL be ignored; digits hold.
REQ-015 In SET_MIN, inc_btn SHALL increment minutes 00..59 with wrap to 00, no carry, no hr_co, seconds unchanged.
REQ-016 In SET_SEC, inc_btn SHALL increment seconds 00..59 with wrap to 00, no carry into minutes.
REQ-017 inc_btn in RUN SHALL be ignored.
REQ-018 On simultaneous tick and mode_btn in RUN, the tick SHALL be applied and the state SHALL change in the same cycle.
REQ-019 On simultaneous mode_btn and inc_btn in a SET state, the increment SHALL apply to the field selected before the transition.
REQ-020 blink SHALL be a registered decode of state; mode output SHALL equal the state register.

Reset
REQ-021 While rst is high at a clk edge, all digits SHALL be 0, mode RUN, blink 0, hr_co 0; rst SHALL override tick and buttons.
REQ-022 rst asserted mid-SET SHALL discard the partial edit and return to RUN at 00:00.

Configuration
REQ-023 Macro TIME_SEQ_CTRL_HOUR_EN, when defined, SHALL add outputs hr_lo, hr_hi (4 bits each, 00..23) and state SET_HOUR inserted after SET_SEC.
REQ-024 With the macro, the 59:59 rollover SHALL increment hours, 23:59:59 SHALL wrap to 00:00:00, hr_co SHALL pulse only at 23:59:59->00:00:00, and SET_HOUR inc_btn SHALL wrap 23->00 without carry.
REQ-025 Without the macro, no hour logic, ports or SET_HOUR state SHALL exist; encoding 3 SHALL be unreachable.

Structure
REQ-026 State encoding constants and digit limits (9, 5, 23) SHALL live in shared package time_seq_pkg.
REQ-027 A sub-module digit_cnt (parameterised modulus, sync clear, en, load-increment, carry out) SHALL be instantiated once per digit.

Verification
REQ-028 Reset, then 75 ticks in RUN -> min_hi:min_lo:sec_hi:sec_lo = 0:1:1:5, hr_co never asserted.
REQ-029 Preload 59:58, 2 ticks -> 00:00 after the second, hr_co high exactly one cycle.
REQ-030 mode_btn once, inc_btn 61 times -> minutes 01, seconds unchanged, ticks during SET_MIN ignored, blink=1.
REQ-031 Same-cycle tick and mode_btn at 00:09 -> 00:10 and mode=SET_MIN next cycle.
REQ-032 rst pulse while in SET_SEC at 12:34 -> 00:00, mode=RUN, blink=0 next cycle.
REQ-033 With TIME_SEQ_CTRL_HOUR_EN, preload 23:59:59, one tick -> 00:00:00, hr_co one-cycle pulse.
